// File: rtl/qam_pkg.sv
// qam_pkg: mode encoding, bits-per-symbol, Gray-to-level tables and parameter checks for the QAM mapper
package qam_pkg;
  typedef enum logic [1:0] {MODE_BPSK, MODE_QPSK, MODE_QAM16, MODE_QAM64} mode_e;

  localparam logic signed [3:0] LVL2 [4] = '{-4'sd3, -4'sd1, 4'sd3, 4'sd1};
  localparam logic signed [3:0] LVL3 [8] = '{-4'sd7, -4'sd5, -4'sd1, -4'sd3, 4'sd7, 4'sd5, 4'sd1, 4'sd3};

  function automatic logic [2:0] bits_per_mode(input mode_e m);
    return m == MODE_BPSK ? 3'd1 : {m, 1'b0};
  endfunction

  // Zero bits on an axis (BPSK Q) maps to level 0.
  function automatic logic signed [3:0] gray_level(input logic [2:0] code, input logic [1:0] nbits);
    return nbits == 2'd0 ? 4'sd0 :
           nbits == 2'd1 ? (code[0] ? 4'sd1 : -4'sd1) :
           nbits == 2'd2 ? LVL2[code[1:0]] : LVL3[code];
  endfunction

  function automatic bit amp_ok(input int amp, input int sample_w);
    return amp > 0 && 64'(7 * amp) < (64'd1 << (sample_w - 1));
  endfunction
endpackage

// File: rtl/qam_level_lut.sv
// qam_level_lut: Gray-coded bit group to signed odd PAM level for one axis
module qam_level_lut
  import qam_pkg::*;
(
  input  logic [2:0]        i_bits,
  input  logic [1:0]        i_nbits,
  output logic signed [3:0] o_level
);
  assign o_level = gray_level(i_bits, i_nbits);
endmodule

// File: rtl/qam_stream_mapper.sv
// qam_stream_mapper: streaming BPSK/QPSK/16-QAM/64-QAM mapper with a bit reservoir and packet-end flush
module qam_stream_mapper
  import qam_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int SAMPLE_W = 16,
  parameter int AMP      = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [2*SAMPLE_W-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);
  localparam int BUF_W = 2 * IN_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic signed [SAMPLE_W-1:0] AMP_S = SAMPLE_W'(AMP);

  if (IN_W < 6 || IN_W > 32) begin : g_bad_in_w
    $error("IN_W must be within 6..32");
  end
  if (!amp_ok(AMP, SAMPLE_W)) begin : g_bad_amp
    $error("7*AMP does not fit in SAMPLE_W signed");
  end

  // Valid bits sit MSB-aligned in r_buf; everything below them is kept zero so short pops pad for free.
  logic [BUF_W-1:0]      r_buf;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_last_pend;
  mode_e                 r_mode;
  logic [2*SAMPLE_W-1:0] r_data;
  logic                  r_valid;
  logic                  r_mlast;

  logic [2:0]                  w_k;
  logic [CNT_W-1:0]            w_k_cnt;
  logic [CNT_W-1:0]            w_take;
  logic [CNT_W-1:0]            w_cnt_mid;
  logic                        w_acc;
  logic                        w_pop;
  logic [5:0]                  w_sym;
  logic [1:0]                  w_half;
  logic [2:0]                  w_ibits;
  logic [2:0]                  w_qbits;
  logic signed [3:0]           w_lvl_i;
  logic signed [3:0]           w_lvl_q;
  logic signed [SAMPLE_W-1:0]  w_i_ext;
  logic signed [SAMPLE_W-1:0]  w_q_ext;
  logic signed [SAMPLE_W-1:0]  w_i;
  logic signed [SAMPLE_W-1:0]  w_q;

  assign w_k       = bits_per_mode(r_mode);
  assign w_k_cnt   = CNT_W'(w_k);
  assign w_take    = r_cnt < w_k_cnt ? r_cnt : w_k_cnt;
  assign s_ready   = rst & ~r_last_pend & (r_cnt <= CNT_W'(BUF_W - IN_W));
  assign w_acc     = s_valid & s_ready;
  assign w_pop     = (r_cnt >= w_k_cnt | (r_last_pend & r_cnt != '0)) & (~r_valid | m_ready);
  assign w_cnt_mid = w_pop ? r_cnt - w_take : r_cnt;

  assign w_sym   = r_buf[BUF_W-1 -: 6];
  assign w_half  = w_k == 3'd1 ? 2'd1 : w_k[2:1];
  assign w_ibits = w_half == 2'd1 ? {2'b0, w_sym[5]} : w_half == 2'd2 ? {1'b0, w_sym[5:4]} : w_sym[5:3];
  assign w_qbits = w_half == 2'd1 ? {2'b0, w_sym[4]} : w_half == 2'd2 ? {1'b0, w_sym[3:2]} : w_sym[2:0];

  qam_level_lut u_lut_i (.i_bits(w_ibits), .i_nbits(w_half), .o_level(w_lvl_i));
  qam_level_lut u_lut_q (.i_bits(w_qbits), .i_nbits(r_mode == MODE_BPSK ? 2'd0 : w_half), .o_level(w_lvl_q));

  assign w_i_ext = {{(SAMPLE_W-4){w_lvl_i[3]}}, w_lvl_i};
  assign w_q_ext = {{(SAMPLE_W-4){w_lvl_q[3]}}, w_lvl_q};
  assign w_i     = w_i_ext * AMP_S;
  assign w_q     = w_q_ext * AMP_S;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_last_pend <= 1'b0;
      r_mode      <= MODE_BPSK;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_mlast     <= 1'b0;
    end else begin
      r_buf   <= (w_pop ? r_buf << w_k : r_buf) | (w_acc ? {s_data, {IN_W{1'b0}}} >> w_cnt_mid : '0);
      r_cnt   <= w_cnt_mid + (w_acc ? CNT_W'(IN_W) : '0);
      r_valid <= w_pop | (r_valid & ~m_ready);
      if (w_acc && r_cnt == '0)
        r_mode <= mode_e'(mode);
      if (w_acc && s_last)
        r_last_pend <= 1'b1;
      else if (w_pop && r_last_pend && w_cnt_mid == '0)
        r_last_pend <= 1'b0;
      if (w_pop) begin
        r_data  <= {w_q, w_i};
        r_mlast <= r_last_pend && w_cnt_mid == '0;
      end else if (m_ready)
        r_mlast <= 1'b0;
    end
  end

  assign m_data  = r_data;
  assign m_valid = r_valid;
  assign m_last  = r_mlast;
endmodule

// File: tb/tb_qam_stream_mapper.sv
// tb_qam_stream_mapper: queue-based reference model with per-cycle compare plus directed literal checks
module tb_qam_stream_mapper;
  localparam int IN_W = 8;
  localparam int G2 [4] = '{-3, -1, 3, 1};
  localparam int G3 [8] = '{-7, -5, -1, -3, 7, 5, 1, 3};
  typedef logic [32:0] sym_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;

  int vec = 0;
  int err = 0;
  bit started = 0;

  bit          mb[$];
  bit          lp, ev, el, acc;
  logic [31:0] ed;
  logic [1:0]  mq;
  sym_t        cap[$];
  sym_t        exq[$];

  qam_stream_mapper #(.IN_W(8), .SAMPLE_W(16), .AMP(2048)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic int lvl(int n, int c);
    if (n == 1) return c != 0 ? 1 : -1;
    if (n == 2) return G2[c];
    return G3[c];
  endfunction

  function automatic sym_t mk(int li, int lq, bit l);
    return {l, 16'(lq * 2048), 16'(li * 2048)};
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: bits live in a queue, symbols are sliced off the front with plain integer arithmetic.
  always @(posedge clk) begin
    int k, h, li, lq, sz;
    bit b [6];
    if (!rst) begin
      mb.delete(); lp = 0; ev = 0; el = 0; ed = '0; mq = 2'd0; acc = 0;
    end else begin
      k   = mq == 2'd0 ? 1 : 2 * int'(mq);
      sz  = mb.size();
      acc = s_valid && !lp && sz <= IN_W;
      if ((sz >= k || (lp && sz > 0)) && (!ev || m_ready)) begin
        for (int i = 0; i < 6; i++) b[i] = (i < k && mb.size() > 0) ? mb.pop_front() : 1'b0;
        h = k == 1 ? 1 : k / 2;
        li = 0; lq = 0;
        for (int i = 0; i < h; i++) li = li * 2 + int'(b[i]);
        for (int i = h; i < k; i++) lq = lq * 2 + int'(b[i]);
        ed = {16'((k == 1 ? 0 : lvl(h, lq)) * 2048), 16'(lvl(h, li) * 2048)};
        el = lp && mb.size() == 0;
        if (el) lp = 0;
        ev = 1;
      end else if (m_ready) ev = 0;
      if (acc) begin
        if (sz == 0) mq = mode;
        for (int i = 0; i < IN_W; i++) mb.push_back(s_data[IN_W-1-i]);
        if (s_last) lp = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("s_ready", 64'(s_ready), 64'(rst && !lp && mb.size() <= IN_W));
      chk("m_valid", 64'(m_valid), 64'(ev));
      if (ev) begin
        chk("m_data", 64'(m_data), 64'(ed));
        chk("m_last", 64'(m_last), 64'(el));
      end
      if (rst && m_valid && m_ready) cap.push_back({m_last, m_data});
    end
  end

  task automatic send(logic [7:0] d, bit l);
    s_data = d; s_last = l; s_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (acc) return;
    end
    vec++; err++;
    $display("FAIL send_timeout: word %0h not accepted within 100 cycles", d);
  endtask

  task automatic drain();
    s_valid = 1'b0; s_last = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (mb.size() == 0 && !ev) return;
    end
    vec++; err++;
    $display("FAIL drain_timeout: reservoir holds %0d bits, valid %0b", mb.size(), ev);
  endtask

  task automatic ex(int li, int lq, bit l);
    exq.push_back(mk(li, lq, l));
  endtask

  task automatic ex_qpsk_1e(bit l);
    ex(-1, -1, 0); ex(-1, 1, 0); ex(1, 1, 0); ex(1, -1, l);
  endtask

  task automatic chk_cap(string n);
    chk({n, "_count"}, 64'(cap.size()), 64'(exq.size()));
    for (int i = 0; i < exq.size() && i < cap.size(); i++) chk(n, 64'(cap[i]), 64'(exq[i]));
    cap.delete(); exq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    byte a5;
    a5 = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    started = 1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    mode = 2'd1; cap.delete();
    send(8'h1E, 1);
    chk("t1_lat_accept", 64'(m_valid), 64'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_lat_next", 64'(m_valid), 64'd1);
    drain();
    ex_qpsk_1e(1);
    chk_cap("t1_qpsk");

    mode = 2'd2;
    send(8'h1E, 1);
    drain();
    ex(-3, -1, 0); ex(1, 3, 1);
    chk_cap("t2_qam16");

    mode = 2'd3;
    send(8'hFF, 0);
    send(8'h00, 1);
    drain();
    ex(3, 3, 0); ex(1, -7, 0); ex(-7, -7, 1);
    chk_cap("t3_qam64");

    mode = 2'd0; m_ready = 1'b0;
    send(8'hA5, 0);
    send(8'hA5, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("t4_stall_s_ready", 64'(s_ready), 64'd0);
    chk("t4_stall_m_valid", 64'(m_valid), 64'd1);
    chk("t4_stall_m_data", 64'(m_data), 64'h0000_0800);
    m_ready = 1'b1;
    send(8'hA5, 0);
    send(8'hA5, 1);
    drain();
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 8; b++)
        ex(a5[7-b] ? 1 : -1, 0, w == 3 && b == 7);
    chk_cap("t4_bpsk");

    send(8'hA5, 1);
    s_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_m_last", 64'(m_last), 64'd0);
    chk("t5_rst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_release_s_ready", 64'(s_ready), 64'd1);
    cap.delete();
    mode = 2'd1;
    send(8'h1E, 1);
    drain();
    ex_qpsk_1e(1);
    chk_cap("t5_after_rst");

    mode = 2'd1;
    send(8'h1E, 0);
    mode = 2'd2;
    send(8'h1E, 1);
    drain();
    ex_qpsk_1e(0); ex_qpsk_1e(1);
    chk_cap("t6_mode_hold");
    send(8'h1E, 1);
    drain();
    ex(-3, -1, 0); ex(1, 3, 1);
    chk_cap("t6_mode_next");

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
